// File: rtl/nios_core_key_pio.sv
//------------------------------------------------------------------------------
// nios_core_key_pio : Avalon-MM input PIO with sync, debounce, edge capture, IRQ
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module nios_core_key_pio #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1,
  parameter int IDLE_LEVEL      = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [WIDTH-1:0] c_IDLE = (IDLE_LEVEL != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  localparam int               c_CW   = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  localparam logic [1:0] c_ADDR_DATA = 2'd0;
  localparam logic [1:0] c_ADDR_MASK = 2'd2;
  localparam logic [1:0] c_ADDR_CAP  = 2'd3;

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] w_deb;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;
  logic [31:0]      r_readdata;

  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= c_IDLE;
      r_s2 <= c_IDLE;
    end else begin
      r_s1 <= in_port;
      r_s2 <= r_s1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      logic [WIDTH-1:0] r_deb;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_deb <= c_IDLE;
        else          r_deb <= r_s2;
      end
      assign w_deb = r_deb;
    end else begin : g_debounce
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [c_CW-1:0] r_cnt;
        logic            r_deb;
        // Any return to the accepted level restarts the stability count.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            r_cnt <= '0;
            r_deb <= c_IDLE[i];
          end else if (r_s2[i] == r_deb) begin
            r_cnt <= '0;
          end else if (r_cnt == c_CW'(DEBOUNCE_CYCLES - 1)) begin
            r_cnt <= '0;
            r_deb <= r_s2[i];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        assign w_deb[i] = r_deb;
      end
    end
  endgenerate

  assign w_rise = w_deb & ~r_prev;
  assign w_fall = ~w_deb & r_prev;

  generate
    if (EDGE_TYPE == 0) begin : g_edge_rise
      assign w_edge = w_rise;
    end else if (EDGE_TYPE == 1) begin : g_edge_fall
      assign w_edge = w_fall;
    end else begin : g_edge_any
      assign w_edge = w_rise | w_fall;
    end
  endgenerate

  assign w_wr  = chipselect & ~write_n;
  assign w_clr = (w_wr && (address == c_ADDR_CAP)) ? writedata[WIDTH-1:0] : '0;

  // A new edge is OR-ed in after the clear so it wins a same-cycle W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= c_IDLE;
      r_mask <= '0;
      r_cap  <= '0;
    end else begin
      r_prev <= w_deb;
      r_cap  <= (r_cap & ~w_clr) | w_edge;
      if (w_wr && (address == c_ADDR_MASK)) r_mask <= writedata[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      case (address)
        c_ADDR_DATA: r_readdata <= 32'(w_deb);
        c_ADDR_MASK: r_readdata <= 32'(r_mask);
        c_ADDR_CAP:  r_readdata <= 32'(r_cap);
        default:     r_readdata <= '0;
      endcase
    end
  end

  assign readdata = r_readdata;
  assign irq      = |(r_cap & r_mask);

endmodule

`default_nettype wire

// File: tb/tb_nios_core_key_pio.sv
//------------------------------------------------------------------------------
// tb_nios_core_key_pio : scoreboard bench for the key PIO (DEBOUNCE_CYCLES=4, falling edge)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_nios_core_key_pio;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [15:0] in_port;
  logic [31:0] readdata;
  logic        irq;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp_v;

  always #5 clk = ~clk;

  nios_core_key_pio #(
    .WIDTH(16), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .IDLE_LEVEL(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a read address and queue the value the bench expects back one edge later.
  task automatic read_req(input logic [1:0] a, input logic [31:0] e);
    address = a;
    sb_q.push_back(e);
    tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'hDEAD_BEEF;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; in_port = 16'hFFFF;
    tick(3);
    n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata: got %h want %h", readdata, 32'h0); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    reset_n = 1'b1;
    tick(3);
    read_req(2'd0, 32'h0000_FFFF); exp_v = sb_q.pop_front();
    n_checks++; if (readdata !== exp_v) begin n_fail++; $display("FAIL reset_data: got %h want %h", readdata, exp_v); end
    read_req(2'd2, 32'h0); exp_v = sb_q.pop_front();
    n_checks++; if (readdata !== exp_v) begin n_fail++; $display("FAIL reset_mask: got %h want %h", readdata, exp_v); end
    read_req(2'd3, 32'h0); exp_v = sb_q.pop_front();
    n_checks++; if (readdata !== exp_v) begin n_fail++; $display("FAIL reset_cap: got %h want %h", readdata, exp_v); end
    wr(2'd0, 32'h0000_1234);
    wr(2'd1, 32'hFFFF_FFFF);
    read_req(2'd0, 32'h0000_FFFF); exp_v = sb_q.pop_front();
    n_checks++; if (readdata !== exp_v) begin n_fail++; $display("FAIL data_ro: got %h want %h", readdata, exp_v); end
    read_req(2'd1, 32'h0); exp_v = sb_q.pop_front();
    n_checks++; if (readdata !== exp_v) begin n_fail++; $display("FAIL reserved: got %h want %h", readdata, exp_v); end
  endtask

  task automatic test_bounce;
    in_port = 16'hFFFE;
    tick(3);
    in_port = 16'hFFFF;
    tick(8);
    read_req(2'd0, 32'h0000_FFFF); exp_v = sb_q.pop_front();
    n_checks++; if (readdata !== exp_v) begin n_fail++; $display("FAIL bounce_data: got %h want %h", readdata, exp_v); end
    read_req(2'd3, 32'h0); exp_v = sb_q.pop_front();
    n_checks++; if (readdata !== exp_v) begin n_fail++; $display("FAIL bounce_cap: got %h want %h", readdata, exp_v); end
  endtask

  task automatic test_debounce_fall;
    in_port = 16'hFFFE;
    tick(4);
    read_req(2'd0, 32'h0000_FFFF); exp_v = sb_q.pop_front();
    n_checks++; if (readdata !== exp_v) begin n_fail++; $display("FAIL deb_early: got %h want %h", readdata, exp_v); end
    tick(2);
    read_req(2'd0, 32'h0000_FFFE); exp_v = sb_q.pop_front();
    n_checks++; if (readdata !== exp_v) begin n_fail++; $display("FAIL deb_accept: got %h want %h", readdata, exp_v); end
    read_req(2'd3, 32'h0000_0001); exp_v = sb_q.pop_front();
    n_checks++; if (readdata !== exp_v) begin n_fail++; $display("FAIL fall_cap: got %h want %h", readdata, exp_v); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %b want 0", irq); end
  endtask

  task automatic test_irq_w1c;
    wr(2'd2, 32'hABCD_0001);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_unmask: got %b want 1", irq); end
    read_req(2'd2, 32'h0000_0001); exp_v = sb_q.pop_front();
    n_checks++; if (readdata !== exp_v) begin n_fail++; $display("FAIL mask_upper: got %h want %h", readdata, exp_v); end
    wr(2'd3, 32'h0000_0002);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_other_w1c: got %b want 1", irq); end
    read_req(2'd3, 32'h0000_0001); exp_v = sb_q.pop_front();
    n_checks++; if (readdata !== exp_v) begin n_fail++; $display("FAIL cap_other_w1c: got %h want %h", readdata, exp_v); end
    wr(2'd3, 32'h0000_0001);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_cleared: got %b want 0", irq); end
    read_req(2'd3, 32'h0); exp_v = sb_q.pop_front();
    n_checks++; if (readdata !== exp_v) begin n_fail++; $display("FAIL cap_cleared: got %h want %h", readdata, exp_v); end
  endtask

  task automatic test_set_wins;
    in_port = 16'hFFF6;
    tick(6);
    wr(2'd3, 32'h0000_0008);
    read_req(2'd3, 32'h0000_0008); exp_v = sb_q.pop_front();
    n_checks++; if (readdata !== exp_v) begin n_fail++; $display("FAIL set_wins: got %h want %h", readdata, exp_v); end
    read_req(2'd0, 32'h0000_FFF6); exp_v = sb_q.pop_front();
    n_checks++; if (readdata !== exp_v) begin n_fail++; $display("FAIL data_bit3: got %h want %h", readdata, exp_v); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_bit3_masked: got %b want 0", irq); end
    wr(2'd3, 32'h0000_0008);
    in_port = 16'hFFFE;
    tick(8);
    read_req(2'd3, 32'h0); exp_v = sb_q.pop_front();
    n_checks++; if (readdata !== exp_v) begin n_fail++; $display("FAIL rise_nocap: got %h want %h", readdata, exp_v); end
    read_req(2'd0, 32'h0000_FFFE); exp_v = sb_q.pop_front();
    n_checks++; if (readdata !== exp_v) begin n_fail++; $display("FAIL rise_data: got %h want %h", readdata, exp_v); end
  endtask

  task automatic test_mid_reset;
    wr(2'd2, 32'h0000_FFFF);
    in_port = 16'hFFFC;
    tick(8);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_bit1: got %b want 1", irq); end
    read_req(2'd3, 32'h0000_0002); exp_v = sb_q.pop_front();
    n_checks++; if (readdata !== exp_v) begin n_fail++; $display("FAIL cap_bit1: got %h want %h", readdata, exp_v); end
    in_port = 16'hFFFF;
    tick(4);
    reset_n = 1'b0;
    #1;
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL midrst_irq: got %b want 0", irq); end
    n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL midrst_readdata: got %h want %h", readdata, 32'h0); end
    tick(2);
    reset_n = 1'b1;
    tick();
    read_req(2'd0, 32'h0000_FFFF); exp_v = sb_q.pop_front();
    n_checks++; if (readdata !== exp_v) begin n_fail++; $display("FAIL midrst_data: got %h want %h", readdata, exp_v); end
    read_req(2'd2, 32'h0); exp_v = sb_q.pop_front();
    n_checks++; if (readdata !== exp_v) begin n_fail++; $display("FAIL midrst_mask: got %h want %h", readdata, exp_v); end
    tick(10);
    read_req(2'd3, 32'h0); exp_v = sb_q.pop_front();
    n_checks++; if (readdata !== exp_v) begin n_fail++; $display("FAIL midrst_spurious: got %h want %h", readdata, exp_v); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL midrst_irq_after: got %b want 0", irq); end
  endtask

  initial begin
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    reset_n    = 1'b0;
    in_port    = 16'hFFFF;
    @(posedge clk); #1;
    test_reset();
    test_bounce();
    test_debounce_fall();
    test_irq_w1c();
    test_set_wins();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
